// File: rtl/axis_pkg.sv
// ============================================================================
// Module      : axis_pkg
// Description : Shared helpers for AXI-stream blocks: clog2, grant-index width
//               and the concatenated stream-slice convention.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    // A single-stream block still needs a one-bit grant index.
    function automatic int grant_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    // Stream i of a concatenated bus occupies [i*width +: width].
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_rr_arbiter_rr_select.sv
// ============================================================================
// Module      : rr_select
// Description : Round-robin pick of the first request after last_grant, done
//               as a double-width masked priority encode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_select
    import axis_pkg::*;
#(
    parameter int N = 4,
    localparam int W = grant_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_grant,
    output logic [W-1:0] sel,
    output logic         any
);

    logic [N-1:0]   above;
    logic [2*N-1:0] dbl;
    logic           found;

    always_comb begin
        above = '0;
        for (int i = 0; i < N; i++) begin
            above[i] = (i > int'(last_grant));
        end
        // Lower half holds requests past the pointer, upper half the wrap.
        dbl   = {req, req & above};
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < 2 * N; i++) begin
            if (!found && dbl[i]) begin
                found = 1'b1;
                sel   = W'((i >= N) ? (i - N) : i);
            end
        end
        any = |req;
    end

endmodule

`default_nettype wire

// File: rtl/axis_rr_arbiter.sv
// ============================================================================
// Module      : axis_rr_arbiter
// Description : Round-robin AXI-stream arbiter with registered output stage.
//               Define AXIS_RR_ARBITER_PACKET_EN for packet-level locking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_rr_arbiter
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_INPUTS = 4,
    localparam int GRANT_WIDTH = grant_width(NUM_INPUTS)
) (
    input  logic                             clock,
    input  logic                             resetn,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] idata,
    input  logic [NUM_INPUTS-1:0]            ivalid,
    input  logic [NUM_INPUTS-1:0]            ilast,
    output logic [NUM_INPUTS-1:0]            iready,
    output logic [DATA_WIDTH-1:0]            odata,
    output logic                             olast,
    output logic [GRANT_WIDTH-1:0]           ogrant,
    output logic                             ovalid,
    input  logic                             oready
);

    localparam logic [NUM_INPUTS-1:0]  c_ONE       = NUM_INPUTS'(1);
    localparam logic [GRANT_WIDTH-1:0] c_PTR_RESET = GRANT_WIDTH'(NUM_INPUTS - 1);

    logic [NUM_INPUTS-1:0]  eligible;
    logic [GRANT_WIDTH-1:0] sel;
    logic                   any;
    logic                   load;

    logic [DATA_WIDTH-1:0]  odata_q,   odata_d;
    logic                   olast_q,   olast_d;
    logic [GRANT_WIDTH-1:0] ogrant_q,  ogrant_d;
    logic                   ovalid_q,  ovalid_d;
    logic [GRANT_WIDTH-1:0] pointer_q, pointer_d;

`ifdef AXIS_RR_ARBITER_PACKET_EN
    logic lock_q, lock_d;

    // While locked the pointer names the owning stream.
    always_comb begin
        eligible = lock_q ? (ivalid & (c_ONE << pointer_q)) : ivalid;
    end
`else
    always_comb begin
        eligible = ivalid;
    end
`endif

    rr_select #(
        .N (NUM_INPUTS)
    ) u_rr_select (
        .req        (eligible),
        .last_grant (pointer_q),
        .sel        (sel),
        .any        (any)
    );

    always_comb begin
        load      = (!ovalid_q || oready) && any;
        iready    = load ? (c_ONE << sel) : '0;
        odata_d   = odata_q;
        olast_d   = olast_q;
        ogrant_d  = ogrant_q;
        ovalid_d  = ovalid_q;
        pointer_d = pointer_q;
        if (load) begin
            odata_d   = idata[slice_lo(int'(sel), DATA_WIDTH) +: DATA_WIDTH];
            olast_d   = ilast[sel];
            ogrant_d  = sel;
            ovalid_d  = 1'b1;
            pointer_d = sel;
        end else if (ovalid_q && oready) begin
            ovalid_d = 1'b0;
        end
    end

`ifdef AXIS_RR_ARBITER_PACKET_EN
    always_comb begin
        lock_d = lock_q;
        if (load) begin
            lock_d = !ilast[sel];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            odata_q   <= '0;
            olast_q   <= 1'b0;
            ogrant_q  <= '0;
            ovalid_q  <= 1'b0;
            pointer_q <= c_PTR_RESET;
        end else begin
            odata_q   <= odata_d;
            olast_q   <= olast_d;
            ogrant_q  <= ogrant_d;
            ovalid_q  <= ovalid_d;
            pointer_q <= pointer_d;
        end
    end

    assign odata  = odata_q;
    assign olast  = olast_q;
    assign ogrant = ogrant_q;
    assign ovalid = ovalid_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_rr_arbiter.sv
// ============================================================================
// Module      : tb_axis_rr_arbiter
// Description : Self-checking bench for axis_rr_arbiter against a behavioural
//               round-robin model (packet mode under AXIS_RR_ARBITER_PACKET_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clock = 1'b0;
    logic            resetn;
    logic [N*DW-1:0] idata;
    logic [N-1:0]    ivalid;
    logic [N-1:0]    ilast;
    logic [N-1:0]    iready;
    logic [DW-1:0]   odata;
    logic            olast;
    logic [1:0]      ogrant;
    logic            ovalid;
    logic            oready;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state
    bit        m_ovalid;
    bit [7:0]  m_odata;
    bit        m_olast;
    int        m_ogrant;
    int        m_ptr;
    bit        m_lock;
    bit        m_load;
    int        m_sel;
    int        sent;
    bit        seen1;

    axis_rr_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_INPUTS (N)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .idata  (idata),
        .ivalid (ivalid),
        .ilast  (ilast),
        .iready (iready),
        .odata  (odata),
        .olast  (olast),
        .ogrant (ogrant),
        .ovalid (ovalid),
        .oready (oready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (ptr + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ovalid = 0; m_odata = 0; m_olast = 0; m_ogrant = 0;
        m_ptr = N - 1; m_lock = 0;
    endtask

    task automatic chk_outputs();
        chk("ovalid", {31'd0, ovalid}, {31'd0, m_ovalid});
        chk("odata",  {24'd0, odata},  {24'd0, m_odata});
        chk("olast",  {31'd0, olast},  {31'd0, m_olast});
        chk("ogrant", {30'd0, ogrant}, m_ogrant);
    endtask

    // Called just after a rising edge with inputs already applied.
    task automatic step();
        logic [N-1:0] elig;
        logic [N-1:0] exp_ready;
        #2;
        elig = ivalid;
`ifdef AXIS_RR_ARBITER_PACKET_EN
        if (m_lock) begin
            elig = '0;
            elig[m_ptr] = ivalid[m_ptr];
        end
`endif
        m_sel  = pick(elig, m_ptr);
        m_load = (!m_ovalid || oready) && (m_sel >= 0);
        exp_ready = '0;
        if (m_load) exp_ready[m_sel] = 1'b1;
        chk("iready", {28'd0, iready}, {28'd0, exp_ready});
        @(posedge clock);
        #1;
        if (m_load) begin
            m_odata  = idata[m_sel*DW +: DW];
            m_olast  = ilast[m_sel];
            m_ogrant = m_sel;
            m_ovalid = 1;
            m_ptr    = m_sel;
            m_lock   = !ilast[m_sel];
        end else if (m_ovalid && oready) begin
            m_ovalid = 0;
        end
        chk_outputs();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        model_reset();
        chk_outputs();
        @(posedge clock);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0;
        idata  = '0;
        ivalid = '0;
        ilast  = '0;
        oready = 1'b0;
        #1;
        do_reset();

        // All streams valid: strict 0,1,2,3 rotation
        ivalid = 4'b1111; ilast = 4'b1111; oready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            idata = $urandom;
            step();
            chk("rotation", {30'd0, ogrant}, i % N);
        end

        // Single requester, no bubbles
        ivalid = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            idata = $urandom;
            step();
            chk("single_valid", {31'd0, ovalid}, 1);
        end

        // Backpressure hold and resume
        ivalid = 4'b1111;
        idata = $urandom;
        step();
        oready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idata = $urandom;
            step();
        end
        oready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idata = $urandom;
            step();
        end

        // Wrap-around between streams 1 and 3
        ivalid = 4'b1000;
        step();
        ivalid = 4'b1010;
        step(); chk("wrap0", {30'd0, ogrant}, 1);
        step(); chk("wrap1", {30'd0, ogrant}, 3);
        step(); chk("wrap2", {30'd0, ogrant}, 1);

        // Stream 0 packet on alternate cycles against a busy stream 1
        ivalid = '0;
        do_reset();
        sent = 0;
        seen1 = 0;
        for (int c = 0; c < 10; c++) begin
            ivalid = {2'b00, 1'b1, (c % 2 == 0) && (sent < 3)};
            ilast  = {3'b000, sent == 2};
            idata  = {8'h13, 8'h12, 8'h10, 8'hA0 + 8'(sent)};
            step();
            if (m_load && m_sel == 0) sent++;
`ifdef AXIS_RR_ARBITER_PACKET_EN
            if (m_load && m_sel == 1 && !seen1) begin
                seen1 = 1;
                chk("pkt_order", sent, 3);
            end
`endif
        end

        // Asynchronous reset while holding a locked word
        ivalid = 4'b0001; ilast = 4'b0000; oready = 1'b1;
        idata = $urandom;
        step();
        oready = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        chk_outputs();
        @(posedge clock);
        #1;
        resetn = 1'b1;
        ivalid = 4'b1111; oready = 1'b1;
        idata = $urandom;
        step();
        chk("first_after_reset", {30'd0, ogrant}, 0);

        // Randomised traffic
        for (int i = 0; i < 250; i++) begin
            ivalid = 4'($urandom);
            ilast  = 4'($urandom);
            idata  = $urandom;
            oready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- Shares one AXI-stream sink, typically the write side of a single-clock axis FIFO, between NUM_INPUTS requesting streams.
- Round-robin arbitration with a registered output stage: one word per cycle at full throughput, no combinational path from oready to the outputs.
- Sits in front of the FIFO and sequences which producer may write into it.

Parameters:
- DATA_WIDTH, 8, payload width per stream.
- NUM_INPUTS, 4, number of requesting streams (2..16).
- GRANT_WIDTH, clog2(NUM_INPUTS) (minimum 1), width of the grant index; derived, never overridden.

Ports:
- clock  input  1  rising-edge clock.
- resetn  input  1  reset, asynchronous, active-low.
- idata  input  NUM_INPUTS*DATA_WIDTH  concatenated payloads; stream i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- ivalid  input  NUM_INPUTS  per-stream valid.
- ilast  input  NUM_INPUTS  per-stream end-of-packet marker.
- iready  output  NUM_INPUTS  per-stream ready; at most one bit set (one-hot or zero).
- odata  output  DATA_WIDTH  registered payload.
- olast  output  1  registered copy of the accepted ilast.
- ogrant  output  GRANT_WIDTH  index of the stream that produced the current odata.
- ovalid  output  1  registered valid.
- oready  input  1  downstream ready (e.g. FIFO iready).

Behaviour:
- Reset values: ovalid=0, odata=0, olast=0, ogrant=0. The internal last-grant pointer resets to NUM_INPUTS-1, so the first grant goes to stream 0. The packet lock (feature on) resets to unlocked.
- load = (!ovalid || oready) && (|ivalid_eligible).
- Selection:
  - sel is the first index with ivalid set, searching cyclically from pointer+1 up to pointer (wraps modulo NUM_INPUTS).
  - Selection is purely combinational from ivalid and the pointer. It never depends on oready beyond the load term.
- iready[i] = load && (i == sel). iready depends combinationally on ivalid and on oready through load.
- On load:
  - odata <= idata[sel].
  - olast <= ilast[sel].
  - ogrant <= sel.
  - ovalid <= 1.
  - pointer <= sel.
- If ovalid && oready && !load, then ovalid <= 0 and the data, last and grant registers hold.
- If ovalid && !oready, all output registers hold and every iready bit is 0.
- Latency: an accepted input word appears on the output the next cycle. Sustained throughput is 1 word/cycle while oready=1.
- Fairness: with all inputs continuously valid, grants go 0,1,...,N-1,0,... A stream waits at most NUM_INPUTS-1 transfers (word mode).
- Single requester: grants to it every cycle with no bubbles.
- No requester: ovalid drops after the pending word drains. The pointer holds.
- Mid-operation reset clears the output immediately (asynchronously). Any partially transferred packet is dropped from the arbiter's view; upstream sources must also be reset.
- ilast is ignored for arbitration when the feature is off, but is still forwarded on olast.

Optional Feature:
- Macro: AXIS_RR_ARBITER_PACKET_EN.
- Defined (packet mode):
  - On a load with ilast[sel]=0, the lock is set and the arbiter locks onto sel.
  - While locked, only the locked stream is eligible. Other ivalid bits are masked even if the locked stream stalls.
  - A load of the locked stream with ilast=1 clears the lock. The pointer then advances normally.
  - Packets are never interleaved on the output.
- Undefined: word-level arbitration as above, with no lock register.

Decomposition:
- Shared package axis_pkg holds:
  - a clog2 constant function;
  - a localparam helper for GRANT_WIDTH;
  - the stream-slice indexing convention.
- One natural combinational sub-module, rr_select, with parameter N and ports:
  - req [N];
  - last_grant [clog2 N];
  - sel [clog2 N];
  - any (1 bit).
- rr_select is implemented as a double-width masked priority encode, so it can be reused by later scheduling blocks.

Test Plan:
- Reset, then all ivalid=4'b1111 with oready=1 -> ogrant sequence 0,1,2,3,0,1; ovalid=1 from the cycle after the first load; one iready bit per cycle.
- Only stream 2 valid, oready=1, 5 words -> five consecutive outputs with ogrant=2 and odata matching in order; no bubbles.
- All valid, oready=0 for 3 cycles after the first load -> odata/ogrant held, iready=0000; when oready returns, grant resumes at pointer+1.
- Streams 1 and 3 valid, the pointer at 3 -> next grant is 1 (wrap-around); then 3, then 1.
- Packet mode: stream 0 sends a 3-word packet (ilast on the third) with stream 1 valid throughout and stream 0 valid only on alternate cycles -> output carries 0,0,0 before any 1; iready[1]=0 during the lock.
- Assert resetn low while ovalid=1 and locked -> ovalid, odata, olast, ogrant go to 0 immediately; after release the first grant is stream 0.
